dual_port_ram: RTL and testbench

//   Simple dual-port synchronous RAM: one write port and one read port, shared clock.

---
 rtl/jpeg_mem_pkg.sv | 13 +
 rtl/dual_port_ram_chk.sv | 27 ++
 rtl/dual_port_ram.sv | 60 ++++++
 tb/tb_dual_port_ram.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/jpeg_mem_pkg.sv
// Shared sizing defaults and helpers for the JPEG datapath FIFO storage.
package jpeg_mem_pkg;

  localparam int unsigned FIFO_DEPTH = 32'd16;
  localparam int unsigned FIFO_AW    = 32'd4;
  localparam int unsigned FIFO_WW    = 32'd33;

  // True when an address falls inside the populated part of the array.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned lines);
    return (addr < lines);
  endfunction

endpackage

// File: rtl/dual_port_ram_chk.sv
// Simulation-only watchdog for unknown control inputs on dual_port_ram.
// Bound into every instance so the RAM itself stays a single flat module.
module dual_port_ram_chk (
  input logic clk,
  input logic rst,
  input logic cs,
  input logic rd,
  input logic wr
);

  // An X on a control pin must be reported, never quietly read as 0.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown({cs, rd, wr}))
        else $warning("dual_port_ram: unknown value on cs/rd/wr");
    end
  end

endmodule

bind dual_port_ram dual_port_ram_chk u_chk (
  .clk (clk),
  .rst (rst),
  .cs  (cs),
  .rd  (rd),
  .wr  (wr)
);

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, shared clock.
// Same-address collisions are read-before-write; rd_data clears asynchronously on rst.
module dual_port_ram
  import jpeg_mem_pkg::*;
#(
  parameter int unsigned LINES         = FIFO_DEPTH,
  parameter int unsigned ADDRESS_WIDTH = FIFO_AW,
  parameter int unsigned WORD_WIDTH    = FIFO_WW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [ADDRESS_WIDTH-1:0] rd_add,
  input  logic [ADDRESS_WIDTH-1:0] wr_add,
  input  logic [WORD_WIDTH-1:0]    wr_data,
  output logic [WORD_WIDTH-1:0]    rd_data
);

  if ((LINES > (32'd1 << ADDRESS_WIDTH)) || (WORD_WIDTH < 32'd1)) begin : g_param_err
    $error("dual_port_ram: LINES must not exceed 2**ADDRESS_WIDTH and WORD_WIDTH must be >= 1");
  end

  logic [WORD_WIDTH-1:0] mem_r [0:LINES-1];
  logic [WORD_WIDTH-1:0] rd_data_r;
  logic                  rd_en_s;
  logic                  wr_en_s;
  logic                  rd_ok_s;
  logic                  wr_ok_s;

  // Port qualification and address range decode.
  always_comb begin
    rd_en_s = cs & rd;
    wr_en_s = cs & wr;
    rd_ok_s = addr_in_range(32'(rd_add), LINES);
    wr_ok_s = addr_in_range(32'(wr_add), LINES);
  end

  // Write port; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && wr_ok_s) begin
      mem_r[wr_add] <= wr_data;
    end
  end

  // Read port; the array value sampled here is the pre-write word on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {WORD_WIDTH{1'b0}};
    end else if (rd_en_s) begin
      rd_data_r <= rd_ok_s ? mem_r[rd_add] : {WORD_WIDTH{1'b0}};
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: constant vector table, directed corner
// sequences, then random traffic against an array-based reference model.
module tb_dual_port_ram;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  rd_add;
  logic [3:0]  wr_add;
  logic [32:0] wr_data;
  logic [32:0] rd_data;

  int total;
  int bad;

  logic [32:0] exp_mem [0:15];
  logic [32:0] exp_rd;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  ra;
    logic [3:0]  wa;
    logic [32:0] wd;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl[$];

  dual_port_ram dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .rd_add  (rd_add),
    .wr_add  (wr_add),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, settle.
  task automatic apply(input logic c, input logic r, input logic w,
                       input logic [3:0] ra, input logic [3:0] wa, input logic [32:0] wd);
    cs = c; rd = r; wr = w; rd_add = ra; wr_add = wa; wr_data = wd;
    @(posedge clk);
    if (c && r) exp_rd = exp_mem[ra];
    if (c && w) exp_mem[wa] = wd;
    #1;
  endtask

  initial begin
    logic [32:0] toggled;
    logic [32:0] prev;
    logic [32:0] held;

    total = 0; bad = 0;
    exp_rd = 33'd0;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    rd_add = 4'd0; wr_add = 4'd0; wr_data = 33'd0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 33'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", rd_data, 33'd0);
    rst = 1'b0;

    // Vector table: fill, read back, cs gating, collision, hold.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 4'(i), 33'h1_0000_0000 | 33'(i), 33'd0});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 4'(i), 4'd0, 33'd0, 33'h1_0000_0000 | 33'(i)});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 33'h0_0000_AAAA, 33'h1_0000_000F});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 33'd0,           33'h1_0000_000F});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 33'd0,           33'h1_0000_0003});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 33'h0_0000_0055, 33'h1_0000_0003});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 33'h0_0000_0077, 33'h0_0000_0055});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 33'd0,           33'h0_0000_0077});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 33'h1_DEAD_BEEF, 33'h0_0000_0077});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd6, 4'd7, 33'h1_2222_2222, 33'h1_0000_0006});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 33'd0,           33'h1_2222_2222});
    foreach (tbl[k]) begin
      apply(tbl[k].cs, tbl[k].rd, tbl[k].wr, tbl[k].ra, tbl[k].wa, tbl[k].wd);
      check($sformatf("vec%0d", k), rd_data, tbl[k].exp);
    end

    // Asynchronous reset mid-run with a loaded output register.
    apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 33'h1_2345_6789);
    apply(1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 33'd0);
    check("rst_preload", rd_data, 33'h1_2345_6789);
    #2 rst = 1'b1;
    #1 check("rst_async", rd_data, 33'd0);
    exp_rd = 33'd0;
    for (int i = 0; i < 3; i++) begin
      cs = 1'b1; rd = 1'b1; rd_add = 4'd9;
      @(posedge clk);
      #1 check($sformatf("rst_hold%0d", i), rd_data, 33'd0);
    end
    rst = 1'b0;
    apply(1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 33'd0);
    check("rst_first_access", rd_data, 33'h1_2345_6789);

    // Concurrent ports: read addr 0 while hammering addr 15, all bits toggling.
    apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 33'h1_FFFF_FFFF);
    apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 33'd0);
    apply(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 33'd0);
    check("conc_zero", rd_data, 33'd0);
    prev = rd_data;
    toggled = 33'd0;
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, (i % 2 == 0) ? 33'd0 : 33'h1_FFFF_FFFF);
      check($sformatf("conc_rd%0d", i), rd_data, 33'h1_FFFF_FFFF);
      toggled = toggled | (rd_data ^ prev);
      prev = rd_data;
    end
    check("conc_toggle", toggled, 33'h1_FFFF_FFFF);
    apply(1'b1, 1'b1, 1'b0, 4'd15, 4'd0, 33'd0);
    check("conc_last_wr", rd_data, 33'h1_FFFF_FFFF);

    // Hold: one read then idle with writes still flowing.
    apply(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 33'd0);
    held = 33'h1_0000_0002;
    check("hold_read", rd_data, held);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, 1'b1, 4'd2, 4'(i), {1'b0, $urandom});
      check($sformatf("hold%0d", i), rd_data, held);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {1'($urandom_range(0, 1)), $urandom});
      check($sformatf("rand%0d", i), rd_data, exp_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
